// File: rtl/neosd_clk_seq.sv
// neosd_clk_seq
//   Sequencer and arbiter in front of the neosd SD clock generator. Owns the
//   divider select, runs the power-up clock burst, merges the CMD and DATA
//   clock requests into the generator's request vector, appends a trailing
//   run of SD clocks after the last requester releases, and retunes the
//   divider only while no SD clock is being requested.
//
//   State table
//     state  | meaning
//     IDLE   | nothing requested; serves pending switch, then init, then requests
//     SWITCH | one cycle: latched divider select is applied to the generator
//     INIT   | power-up burst, counts INIT_CYCLES qualifying strobes
//     RUN    | clock follows {dat_req_i, cmd_req_i}, grants mirror requests
//     TAIL   | trailing burst of TAIL_CYCLES strobes; any request returns to RUN
//
//   Ports
//     clk_i, rstn_i       system clock, synchronous active-low reset
//     clkstrb_i           one pulse per SD clock period from the generator
//     sd_clk_en_i         generator reports the SD clock running (not stalled)
//     sd_clksel_o         divider select to the generator
//     sd_clk_req_o        request vector: bit0 CMD/init/tail, bit1 DATA
//     cfg_clksel_i/_we_i  new divider select and its write strobe
//     cfg_busy_o          a divider change is pending
//     init_start_i        requests the power-up burst
//     init_done_o         one-cycle pulse when the burst completes
//     cmd_req_i/dat_req_i level requests from the CMD / DATA FSMs
//     cmd_gnt_o/dat_gnt_o grants
//     idle_o              state is IDLE and nothing is requested
module neosd_clk_seq #(
  parameter int unsigned INIT_CYCLES  = 74,
  parameter int unsigned TAIL_CYCLES  = 8,
  parameter logic [2:0]  RESET_CLKSEL = 3'd7,
  parameter int unsigned CNT_W        = 7
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clkstrb_i,
  input  logic       sd_clk_en_i,
  output logic [2:0] sd_clksel_o,
  output logic [1:0] sd_clk_req_o,
  input  logic [2:0] cfg_clksel_i,
  input  logic       cfg_clksel_we_i,
  output logic       cfg_busy_o,
  input  logic       init_start_i,
  output logic       init_done_o,
  input  logic       cmd_req_i,
  input  logic       dat_req_i,
  output logic       cmd_gnt_o,
  output logic       dat_gnt_o,
  output logic       idle_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWITCH = 3'd1,
    ST_INIT   = 3'd2,
    ST_RUN    = 3'd3,
    ST_TAIL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(INIT_CYCLES);
  localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(TAIL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_pend_q, sw_pend_d;
  logic             init_pend_q, init_pend_d;
  logic [2:0]       clksel_pend_q, clksel_pend_d;
  logic [2:0]       clksel_q, clksel_d;
  logic [1:0]       req_q, req_d;
  logic             cmd_gnt_q, cmd_gnt_d;
  logic             dat_gnt_q, dat_gnt_d;
  logic             init_done_q, init_done_d;
  logic             idle_q, idle_d;

  logic             qual_strb;
  logic             cnt_last;
  logic             any_req;
  logic             sw_pend_now;
  logic             init_pend_now;
  logic [CNT_W-1:0] cnt_dec;

  always_comb begin
    qual_strb     = clkstrb_i & sd_clk_en_i;
    // Treat a zero count as terminal too, so a burst can never hang.
    cnt_last      = (cnt_q <= CNT_ONE);
    cnt_dec       = (cnt_q != '0) ? (cnt_q - CNT_ONE) : cnt_q;
    any_req       = cmd_req_i | dat_req_i;
    // Same-cycle write / start pulses already count as pending in IDLE.
    sw_pend_now   = sw_pend_q | cfg_clksel_we_i;
    init_pend_now = init_pend_q | init_start_i;

    state_d       = state_q;
    cnt_d         = cnt_q;
    sw_pend_d     = sw_pend_now;
    init_pend_d   = init_pend_now;
    clksel_pend_d = cfg_clksel_we_i ? cfg_clksel_i : clksel_pend_q;
    clksel_d      = clksel_q;
    init_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sw_pend_now) begin
          state_d = ST_SWITCH;
        end else if (init_pend_now) begin
          state_d = ST_INIT;
          cnt_d   = INIT_LD;
        end else if (any_req) begin
          state_d = ST_RUN;
        end
      end

      ST_SWITCH: begin
        // Apply the value latched so far; a write landing this very cycle
        // stays pending and gets its own SWITCH pass.
        clksel_d  = clksel_pend_q;
        sw_pend_d = cfg_clksel_we_i;
        state_d   = ST_IDLE;
      end

      ST_INIT: begin
        if (qual_strb) begin
          cnt_d = cnt_dec;
          if (cnt_last) begin
            init_pend_d = 1'b0;
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        if (!any_req) begin
          state_d = ST_TAIL;
          cnt_d   = TAIL_LD;
        end
      end

      ST_TAIL: begin
        // A returning requester abandons the tail outright.
        if (any_req) begin
          state_d = ST_RUN;
        end else if (qual_strb) begin
          cnt_d = cnt_dec;
          if (cnt_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are a function of the next state so they register alongside it.
    req_d     = 2'b00;
    cmd_gnt_d = 1'b0;
    dat_gnt_d = 1'b0;
    case (state_d)
      ST_INIT, ST_TAIL: begin
        req_d = 2'b01;
      end
      ST_RUN: begin
        req_d     = {dat_req_i, cmd_req_i};
        cmd_gnt_d = cmd_req_i;
        dat_gnt_d = dat_req_i;
      end
      default: begin
        req_d = 2'b00;
      end
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sw_pend_q     <= 1'b0;
      init_pend_q   <= 1'b0;
      clksel_pend_q <= RESET_CLKSEL;
      clksel_q      <= RESET_CLKSEL;
      req_q         <= 2'b00;
      cmd_gnt_q     <= 1'b0;
      dat_gnt_q     <= 1'b0;
      init_done_q   <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sw_pend_q     <= sw_pend_d;
      init_pend_q   <= init_pend_d;
      clksel_pend_q <= clksel_pend_d;
      clksel_q      <= clksel_d;
      req_q         <= req_d;
      cmd_gnt_q     <= cmd_gnt_d;
      dat_gnt_q     <= dat_gnt_d;
      init_done_q   <= init_done_d;
      idle_q        <= idle_d;
    end
  end

  assign sd_clksel_o  = clksel_q;
  assign sd_clk_req_o = req_q;
  assign cfg_busy_o   = sw_pend_q;
  assign init_done_o  = init_done_q;
  assign cmd_gnt_o    = cmd_gnt_q;
  assign dat_gnt_o    = dat_gnt_q;
  assign idle_o       = idle_q;

endmodule
